// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage with load data extraction and a single-outstanding-load FSM
// Optional feature macro: WB_MISALIGN_CHECK_EN (flag misaligned loads and suppress their write)
module wb_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_reg_write,
    input  logic                      ex_is_load,
    input  logic [2:0]                ex_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic [XLEN-1:0]           ex_result,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           write_data,
    output logic                      busy,
    output logic                      misalign_err
);
    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_ld_we;
    logic [REG_ADDR_WIDTH-1:0] r_ld_rd;
    logic [2:0]                r_ld_f3;
    logic [1:0]                r_ld_off;
    logic                      r_write_en;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [XLEN-1:0]           r_write_data;
    logic                      r_misalign;
    logic                      w_xfer;
    logic                      w_done;
    logic                      w_mis;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [XLEN-1:0]           w_ld_data;

    assign ex_ready     = r_state == IDLE;
    assign busy         = r_state == LOAD_WAIT;
    assign write_en     = r_write_en;
    assign rd_addr      = r_rd_addr;
    assign write_data   = r_write_data;
    assign misalign_err = r_misalign;

    assign w_xfer = ex_valid && r_state == IDLE;
    assign w_done = mem_rvalid && r_state == LOAD_WAIT;

    // Byte/halfword lanes selected by the captured address offset
    assign w_byte = mem_rdata[{r_ld_off, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_ld_off[1], 4'b0000} +: 16];

    // Any funct3 that is not a byte or halfword form falls through to a full word
    assign w_ld_data = r_ld_f3 == 3'b000 ? {{(XLEN-8){w_byte[7]}}, w_byte} :
                       r_ld_f3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_byte} :
                       r_ld_f3 == 3'b001 ? {{(XLEN-16){w_half[15]}}, w_half} :
                       r_ld_f3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_half} :
                       mem_rdata;

`ifdef WB_MISALIGN_CHECK_EN
    assign w_mis = r_ld_f3[1:0] == 2'b01 ? r_ld_off[0] :
                   r_ld_f3[1:0] == 2'b00 ? 1'b0 :
                   r_ld_off != 2'b00;
`else
    assign w_mis = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: a load parks the stage until its data returns
    always_comb begin
        w_next = r_state;
        if (w_xfer && ex_is_load) w_next = LOAD_WAIT;
        else if (w_done)          w_next = IDLE;
    end

    // Capture the load context needed when the memory data arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_we  <= 1'b0;
            r_ld_rd  <= '0;
            r_ld_f3  <= 3'b000;
            r_ld_off <= 2'b00;
        end else if (w_xfer && ex_is_load) begin
            r_ld_we  <= ex_reg_write;
            r_ld_rd  <= ex_rd_addr;
            r_ld_f3  <= ex_funct3;
            r_ld_off <= ex_result[1:0];
        end
    end

    // Register-file write port; strobes last one cycle, address/data hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_en   <= 1'b0;
            r_rd_addr    <= '0;
            r_write_data <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_misalign <= 1'b0;
            if (w_xfer && !ex_is_load) begin
                r_write_en   <= ex_reg_write && ex_rd_addr != '0;
                r_rd_addr    <= ex_rd_addr;
                r_write_data <= ex_result;
            end else if (w_done) begin
                r_write_en   <= r_ld_we && r_ld_rd != '0 && !w_mis;
                r_rd_addr    <= r_ld_rd;
                r_write_data <= w_ld_data;
                r_misalign   <= w_mis;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic        busy;
    logic        misalign_err;

    typedef struct {
        int          cyc;
        logic        we;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .ex_rd_addr(ex_rd_addr), .ex_result(ex_result), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .write_en(write_en), .rd_addr(rd_addr),
        .write_data(write_data), .busy(busy), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe or misalign pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (write_en || misalign_err)) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d we=%b mis=%b rd=%0d data=%h, required no output", cyc, write_en, misalign_err, rd_addr, write_data);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || write_en != e.we || misalign_err != e.mis || (e.we && (rd_addr != e.rd || write_data != e.d))) begin
                    errors++;
                    $display("FAIL %s got cyc=%0d we=%b mis=%b rd=%0d data=%h, required cyc=%0d we=%b mis=%b rd=%0d data=%h",
                             e.name, cyc, write_en, misalign_err, rd_addr, write_data, e.cyc, e.we, e.mis, e.rd, e.d);
                end
            end
        end
    end

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h, required %h", n, got, exp);
        end
    endtask

    task automatic alu(string n, logic rw, logic [4:0] rd, logic [31:0] r);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_reg_write = rw; ex_funct3 = 3'b000;
        ex_rd_addr = rd; ex_result = r;
        if (rw && rd != 5'd0) q.push_back('{cyc + 1, 1'b1, 1'b0, rd, r, n});
    endtask

    task automatic idle();
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
    endtask

    task automatic load(string n, logic [2:0] f3, logic [4:0] rd, logic [31:0] addr,
                        logic [31:0] rdata, int lat, logic ewe, logic emis, logic [31:0] ed);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_funct3 = f3;
        ex_rd_addr = rd; ex_result = addr;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk({n, "_ready_wait"}, ex_ready, 0);
        chk({n, "_busy_wait"}, busy, 1);
        repeat (lat - 1) @(negedge clk);
        chk({n, "_busy_late"}, busy, 1);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        q.push_back('{cyc + 1, ewe, emis, rd, ed, n});
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk({n, "_busy_done"}, busy, 0);
        chk({n, "_ready_done"}, ex_ready, 1);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_funct3 = 3'b000;
        ex_rd_addr = 5'd0; ex_result = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_write_en", write_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_misalign", misalign_err, 0);
        rst = 1'b0;
        chk("rst_ready", ex_ready, 1);

        alu("alu_rd5", 1'b1, 5'd5, 32'h1234_5678);
        idle();
        idle();

        load("lb_rd7", 3'b000, 5'd7, 32'h0000_1003, 32'h80FF_FF00, 3, 1'b1, 1'b0, 32'hFFFF_FF80);
        load("lbu_rd7", 3'b100, 5'd7, 32'h0000_1003, 32'h80FF_FF00, 1, 1'b1, 1'b0, 32'h0000_0080);
        load("lhu_rd9", 3'b101, 5'd9, 32'h0000_2002, 32'hBEEF_0001, 2, 1'b1, 1'b0, 32'h0000_BEEF);
        load("lh_rd9", 3'b001, 5'd9, 32'h0000_2002, 32'hBEEF_0001, 2, 1'b1, 1'b0, 32'hFFFF_BEEF);
        load("lh_lo_rd9", 3'b001, 5'd9, 32'h0000_2000, 32'hBEEF_8001, 1, 1'b1, 1'b0, 32'hFFFF_8001);
        load("lw_rd4", 3'b010, 5'd4, 32'h0000_3000, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
        load("lw_undef_f3", 3'b111, 5'd4, 32'h0000_3000, 32'h0BAD_CAFE, 1, 1'b1, 1'b0, 32'h0BAD_CAFE);
`ifdef WB_MISALIGN_CHECK_EN
        load("lw_off2", 3'b010, 5'd6, 32'h0000_3002, 32'h1122_3344, 2, 1'b0, 1'b1, 32'h1122_3344);
`else
        load("lw_off2", 3'b010, 5'd6, 32'h0000_3002, 32'h1122_3344, 2, 1'b1, 1'b0, 32'h1122_3344);
`endif

        alu("alu_rd0", 1'b1, 5'd0, 32'hDEAD_BEEF);
        idle();
        chk("rd0_write_en", write_en, 0);
        chk("rd0_rd_addr", rd_addr, 0);
        chk("rd0_write_data", write_data, 32'hDEAD_BEEF);

        alu("alu_nowrite", 1'b0, 5'd3, 32'h0000_0033);
        idle();
        chk("nowrite_write_en", write_en, 0);
        chk("nowrite_rd_addr", rd_addr, 3);

        alu("b2b_0", 1'b1, 5'd1, 32'h0000_0011);
        alu("b2b_1", 1'b1, 5'd2, 32'h0000_0022);
        alu("b2b_2", 1'b1, 5'd31, 32'hFFFF_0000);
        idle();
        idle();

        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("idle_rvalid_write_en", write_en, 0);
        chk("idle_rvalid_busy", busy, 0);

        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_funct3 = 3'b010;
        ex_rd_addr = 5'd8; ex_result = 32'h0000_4000;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ex_ready, 1);
        chk("abort_write_en", write_en, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("abort_late_rvalid", write_en, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
